// File: rtl/block_chooser_n.sv
// block_chooser_n: parking-route block chooser.
// Watches one request button per parking block. A new press on a block with a
// free slot starts guidance to that block. Guidance ends on a car-parked event,
// on a timeout, or when the target block loses its free slot.
//
// Ports:
//   CKT        clock; all state changes on its rising edge
//   RST        asynchronous active-high reset
//   btn        [NBLK] level request buttons, already synchronous to CKT
//   free       [NBLK] slot-available mask, bit i high = block i has a free slot
//   park_ev    car-parked event, sampled as a level
//   blk        [IDXW] block index shown on the route display
//   guide_vld  high while guiding a car to blk
//   parked     one-cycle pulse when guidance completes
//   timeout    one-cycle pulse when guidance is abandoned on timeout
//   err_full   one-cycle pulse on a press for a full block, or on slot loss
module block_chooser_n #(
  parameter int unsigned NBLK     = 8,
  parameter int unsigned IDXW     = 3,
  parameter int unsigned IDLE_BLK = NBLK - 1,
  parameter int unsigned TMO      = 255
) (
  input  logic            CKT,
  input  logic            RST,
  input  logic [NBLK-1:0] btn,
  input  logic [NBLK-1:0] free,
  input  logic            park_ev,
  output logic [IDXW-1:0] blk,
  output logic            guide_vld,
  output logic            parked,
  output logic            timeout,
  output logic            err_full
);

  localparam int unsigned CNTW = $clog2(TMO + 1);
  localparam logic [IDXW-1:0] IdleIdx = IDXW'(IDLE_BLK);
  localparam logic [CNTW-1:0] CntLast = CNTW'(TMO - 1);
  localparam logic [CNTW-1:0] CntMax  = {CNTW{1'b1}};

  typedef enum logic [1:0] {StIdle, StGuide, StDone} state_e;

  state_e          state_q;
  logic [NBLK-1:0] btn_q;
  logic [CNTW-1:0] cnt_q;

  logic [NBLK-1:0] press;
  logic [NBLK-1:0] vpress;
  logic            any_valid;
  logic            any_reject;
  logic [IDXW-1:0] win_idx;
  logic            slot_lost;

  // Rising-edge press detect and highest-index arbitration among valid presses.
  always_comb begin
    press      = btn & ~btn_q;
    vpress     = press & free;
    any_valid  = |vpress;
    any_reject = |(press & ~free);
    win_idx    = '0;
    for (int i = 0; i < NBLK; i++) begin
      if (vpress[i]) win_idx = IDXW'(i);
    end
  end

  // While guiding, blk holds the target block.
  assign slot_lost = ~free[blk];

  always_ff @(posedge CKT or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      btn_q     <= '0;
      cnt_q     <= '0;
      blk       <= IdleIdx;
      guide_vld <= 1'b0;
      parked    <= 1'b0;
      timeout   <= 1'b0;
      err_full  <= 1'b0;
    end else begin
      btn_q    <= btn;
      parked   <= 1'b0;
      timeout  <= 1'b0;
      err_full <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            state_q   <= StGuide;
            blk       <= win_idx;
            guide_vld <= 1'b1;
            cnt_q     <= '0;
          end else if (any_reject) begin
            err_full <= 1'b1;
          end
        end
        StGuide: begin
          if (park_ev) begin
            // Completion outranks any same-cycle press, slot loss or timeout.
            state_q   <= StDone;
            parked    <= 1'b1;
            guide_vld <= 1'b0;
            blk       <= IdleIdx;
          end else if (any_valid) begin
            blk   <= win_idx;
            cnt_q <= '0;
          end else if (slot_lost) begin
            state_q   <= StIdle;
            err_full  <= 1'b1;
            guide_vld <= 1'b0;
            blk       <= IdleIdx;
          end else begin
            if (any_reject) err_full <= 1'b1;
            if (cnt_q == CntLast) begin
              state_q   <= StIdle;
              timeout   <= 1'b1;
              guide_vld <= 1'b0;
              blk       <= IdleIdx;
            end else if (cnt_q != CntMax) begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        StDone: begin
          // Presses here are dropped; btn_q still tracks so they never re-fire.
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          guide_vld <= 1'b0;
          blk       <= IdleIdx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_chooser_n.sv
// Testbench for block_chooser_n (NBLK=8, TMO=4): directed vector table,
// hand-written reset sequences, then random stimulus against a reference model.
module tb_block_chooser_n;

  localparam int NB  = 8;
  localparam int TMO = 4;
  localparam int IDL = NB - 1;

  logic          CKT;
  logic          RST;
  logic [NB-1:0] btn;
  logic [NB-1:0] free;
  logic          park_ev;
  logic [2:0]    blk;
  logic          guide_vld;
  logic          parked;
  logic          timeout;
  logic          err_full;

  block_chooser_n #(
    .NBLK    (NB),
    .IDXW    (3),
    .IDLE_BLK(IDL),
    .TMO     (TMO)
  ) dut (
    .CKT      (CKT),
    .RST      (RST),
    .btn      (btn),
    .free     (free),
    .park_ev  (park_ev),
    .blk      (blk),
    .guide_vld(guide_vld),
    .parked   (parked),
    .timeout  (timeout),
    .err_full (err_full)
  );

  initial CKT = 1'b0;
  always #5 CKT = ~CKT;

  typedef struct {
    logic [7:0] b;
    logic [7:0] f;
    logic       p;
    int         eblk;
    logic       egv;
    logic       epk;
    logic       eto;
    logic       eer;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: guidance session with an absolute cycle deadline.
  int         cyc;
  bit         m_guiding;
  bit         m_done;
  int         m_target;
  int         m_deadline;
  logic [7:0] m_prev;
  int         e_blk;
  logic       e_gv, e_pk, e_to, e_er;

  function automatic vec_t mk(logic [7:0] b, logic [7:0] f, logic p, int eb, logic gv,
                              logic pk, logic to, logic er);
    vec_t v;
    v.b = b; v.f = f; v.p = p; v.eblk = eb; v.egv = gv; v.epk = pk; v.eto = to; v.eer = er;
    return v;
  endfunction

  task automatic model_reset();
    m_guiding = 0; m_done = 0; m_target = 0; m_deadline = 0; m_prev = '0;
    e_blk = IDL; e_gv = 0; e_pk = 0; e_to = 0; e_er = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic [7:0] f, input logic p);
    logic [7:0] pr, va, rj;
    int hi;
    cyc++;
    pr = b & ~m_prev;
    va = pr & f;
    rj = pr & ~f;
    hi = -1;
    for (int i = 0; i < NB; i++) if (va[i]) hi = i;
    e_pk = 0; e_to = 0; e_er = 0;
    if (m_done) begin
      m_done = 0;
    end else if (!m_guiding) begin
      if (hi >= 0) begin
        m_guiding = 1; m_target = hi; m_deadline = cyc + TMO;
      end else if (rj != 0) begin
        e_er = 1;
      end
    end else if (p) begin
      m_guiding = 0; m_done = 1; e_pk = 1;
    end else if (hi >= 0) begin
      m_target = hi; m_deadline = cyc + TMO;
    end else if (!f[m_target]) begin
      e_er = 1; m_guiding = 0;
    end else begin
      if (rj != 0) e_er = 1;
      if (cyc == m_deadline) begin
        e_to = 1; m_guiding = 0;
      end
    end
    m_prev = b;
    e_blk  = m_guiding ? m_target : IDL;
    e_gv   = m_guiding;
  endtask

  task automatic chk(input string name, input int eb, input logic gv, input logic pk,
                     input logic to, input logic er);
    total++;
    if (blk !== 3'(eb) || guide_vld !== gv || parked !== pk || timeout !== to ||
        err_full !== er) begin
      bad++;
      $display("FAIL %s: got blk=%0d vld=%b parked=%b tmo=%b err=%b, want blk=%0d vld=%b parked=%b tmo=%b err=%b",
               name, blk, guide_vld, parked, timeout, err_full, eb, gv, pk, to, er);
    end
  endtask

  // Drive inputs away from the edge, clock once, advance the model, sample 1 ns later.
  task automatic apply(input logic [7:0] b, input logic [7:0] f, input logic p);
    btn = b; free = f; park_ev = p;
    @(posedge CKT);
    model_step(b, f, p);
    #1;
  endtask

  initial begin
    RST = 1'b1; btn = '0; free = 8'hFF; park_ev = 1'b0;
    cyc = 0;
    model_reset();

    // Directed table: {btn, free, park_ev} -> {blk, guide_vld, parked, timeout, err_full}
    tbl.push_back(mk(8'h20, 8'hFF, 0, 5, 1, 0, 0, 0)); // press 5 -> guide 5
    tbl.push_back(mk(8'h00, 8'hFF, 1, 7, 0, 1, 0, 0)); // parked
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 0, 0)); // done -> idle
    tbl.push_back(mk(8'h02, 8'hFD, 0, 7, 0, 0, 0, 1)); // full block -> err
    tbl.push_back(mk(8'h02, 8'hFD, 0, 7, 0, 0, 0, 0)); // held, no repeat
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(8'h44, 8'hFF, 0, 6, 1, 0, 0, 0)); // 2 and 6 -> 6
    tbl.push_back(mk(8'h00, 8'hFF, 0, 6, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 6, 1, 0, 0, 0));
    tbl.push_back(mk(8'h04, 8'hFF, 0, 2, 1, 0, 0, 0)); // retarget to 2
    tbl.push_back(mk(8'h00, 8'hFF, 0, 2, 1, 0, 0, 0)); // old deadline passes here
    tbl.push_back(mk(8'h00, 8'hFF, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 1, 0)); // timeout after retarget
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(8'h08, 8'hFF, 0, 3, 1, 0, 0, 0)); // press 3
    tbl.push_back(mk(8'h00, 8'hFF, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 1, 0)); // timeout 4 cycles in
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(8'h10, 8'hFF, 0, 4, 1, 0, 0, 0)); // press 4
    tbl.push_back(mk(8'h00, 8'hFF, 0, 4, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 4, 1, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 0, 4, 1, 0, 0, 0));
    tbl.push_back(mk(8'h01, 8'hFF, 1, 7, 0, 1, 0, 0)); // park+press+timeout -> parked
    tbl.push_back(mk(8'h03, 8'hFF, 0, 7, 0, 0, 0, 0)); // press in done ignored
    tbl.push_back(mk(8'h03, 8'hFF, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(8'h40, 8'hFF, 0, 6, 1, 0, 0, 0)); // press 6
    tbl.push_back(mk(8'h40, 8'hBF, 0, 7, 0, 0, 0, 1)); // slot 6 lost
    tbl.push_back(mk(8'h00, 8'hFF, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(8'h00, 8'hFF, 1, 7, 0, 0, 0, 0)); // park_ev in idle ignored

    @(posedge CKT);
    @(posedge CKT);
    #1;
    chk("reset_state", 7, 0, 0, 0, 0);
    RST = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].b, tbl[k].f, tbl[k].p);
      chk($sformatf("vec%0d", k), tbl[k].eblk, tbl[k].egv, tbl[k].epk, tbl[k].eto, tbl[k].eer);
    end

    // Reset mid-guide acts at once; a button held through release is one press.
    apply(8'h20, 8'hFF, 0);
    chk("pre_rst_guide", 5, 1, 0, 0, 0);
    #2 RST = 1'b1;
    #1 chk("rst_async", 7, 0, 0, 0, 0);
    model_reset();
    btn = 8'h10;
    @(posedge CKT);
    #1 chk("rst_hold", 7, 0, 0, 0, 0);
    RST = 1'b0;
    apply(8'h10, 8'hFF, 0);
    chk("held_thru_rst", 4, 1, 0, 0, 0);
    apply(8'h10, 8'hFF, 0);
    chk("held_no_repeat", 4, 1, 0, 0, 0);

    // Random phase: sparse presses, mostly-free mask, occasional park events.
    for (int n = 0; n < 500; n++) begin
      logic [7:0] rb, rf;
      logic       rp;
      rb = 8'($urandom & $urandom & $urandom);
      rf = ~8'($urandom & $urandom & $urandom);
      rp = ($urandom_range(0, 5) == 0);
      apply(rb, rf, rp);
      chk($sformatf("rand%0d", n), e_blk, e_gv, e_pk, e_to, e_er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
